// File: rtl/inst_mem_pipe_if.sv
// Fetch-side bus between an instruction fetcher and inst_mem_pipe.
//   req_valid/req_ready/req_addr : fetch request handshake (byte address)
//   rsp_valid/rsp_ready          : response handshake
//   rsp_inst/rsp_fault           : fetched word and fault flag
//   flush                        : discard any held response (branch redirect)
// master = fetcher, slave = instruction memory.
interface inst_mem_pipe_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_inst;
   logic              rsp_fault;
   logic              flush;

   modport master (
      output req_valid, req_addr, rsp_ready, flush,
      input  req_ready, rsp_valid, rsp_inst, rsp_fault
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, flush,
      output req_ready, rsp_valid, rsp_inst, rsp_fault
   );
endinterface

// File: rtl/inst_mem_pipe.sv
// Instruction memory with a one-deep registered response stage.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : fetch request/response handshake plus flush (slave side)
//   ld_en      : loader write strobe (wins over fetch)
//   ld_addr    : loader byte address, low two bits ignored
//   ld_data    : loader write data
//   fetch_cnt  : number of non-fault responses consumed (wraps)
// Storage powers up filled with NOP_WORD and is never touched by rst.
module inst_mem_pipe #(
   parameter int          DEPTH    = 64,
   parameter int          ADDR_W   = 10,
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic                clk,
   input  logic                rst,
   inst_mem_pipe_if.slave      bus,
   input  logic                ld_en,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [31:0]         ld_data,
   output logic [15:0]         fetch_cnt
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [31:0] mem [DEPTH] = '{default: NOP_WORD};

   logic [ADDR_W-1:0] req_word;
   logic [ADDR_W-1:0] ld_word;
   logic              req_in_range;
   logic              ld_in_range;
   logic              req_fault;
   logic              accept;
   logic              consume;

   // Word addresses; anything above the index bits means out of range
   // (no aliasing/wrap onto low words).
   assign req_word     = bus.req_addr >> 2;
   assign ld_word      = ld_addr >> 2;
   assign req_in_range = (req_word >> IDX_W) == '0;
   assign ld_in_range  = (ld_word >> IDX_W) == '0;
   assign req_fault    = (bus.req_addr[1:0] != 2'b00) || !req_in_range;

   // Loads block fetches, so a read never coincides with a write.
   assign bus.req_ready = !rst && !ld_en && !bus.flush &&
                          (!bus.rsp_valid || bus.rsp_ready);
   assign accept        = bus.req_valid && bus.req_ready;
   assign consume       = bus.rsp_valid && bus.rsp_ready;

   always_ff @(posedge clk) begin
      if (!rst && ld_en && ld_in_range)
         mem[ld_word[IDX_W-1:0]] <= ld_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_fault <= 1'b0;
         bus.rsp_inst  <= NOP_WORD;
         fetch_cnt     <= 16'd0;
      end else begin
         // A consume coinciding with flush still counts.
         if (consume && !bus.rsp_fault)
            fetch_cnt <= fetch_cnt + 16'd1;

         if (bus.flush) begin
            bus.rsp_valid <= 1'b0;
         end else if (accept) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_fault <= req_fault;
            bus.rsp_inst  <= req_fault ? NOP_WORD : mem[req_word[IDX_W-1:0]];
         end else if (consume) begin
            bus.rsp_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_inst_mem_pipe.sv
module tb_inst_mem_pipe;
   localparam int          DEPTH  = 64;
   localparam int          ADDR_W = 10;
   localparam logic [31:0] NOP    = 32'h00000013;

   logic              clk;
   logic              rst;
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [31:0]       ld_data;
   logic [15:0]       fetch_cnt;

   inst_mem_pipe_if #(.ADDR_W(ADDR_W)) bus ();

   inst_mem_pipe #(
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .NOP_WORD(NOP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .fetch_cnt(fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: memory image, the one pending response, consume count.
   logic [31:0] m_mem [DEPTH];
   logic        m_valid;
   logic [31:0] m_inst;
   logic        m_fault;
   logic [15:0] m_cnt;

   int errors = 0;
   int checks = 0;
   logic rdy_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, check req_ready, advance model, check outputs.
   task automatic step(input logic r, input logic rv, input logic [ADDR_W-1:0] ra,
                       input logic rr, input logic fl, input logic le,
                       input logic [ADDR_W-1:0] la, input logic [31:0] ld);
      logic        exp_ready;
      logic        n_valid, n_fault;
      logic [31:0] n_inst;
      logic [15:0] n_cnt;
      int unsigned w;
      rst = r; bus.req_valid = rv; bus.req_addr = ra; bus.rsp_ready = rr;
      bus.flush = fl; ld_en = le; ld_addr = la; ld_data = ld;
      #1;
      exp_ready = !r && !le && !fl && (!m_valid || rr);
      rdy_seen  = bus.req_ready;
      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_ready});
      n_valid = m_valid; n_inst = m_inst; n_fault = m_fault; n_cnt = m_cnt;
      if (r) begin
         n_valid = 1'b0; n_inst = NOP; n_fault = 1'b0; n_cnt = 16'd0;
      end else begin
         if (m_valid && rr && !m_fault) n_cnt = m_cnt + 16'd1;
         if (rv && exp_ready) begin
            w = int'(ra) / 4;
            n_valid = 1'b1;
            n_fault = (int'(ra) % 4 != 0) || (w >= DEPTH);
            n_inst  = n_fault ? NOP : m_mem[w];
         end else if (fl || (m_valid && rr)) begin
            n_valid = 1'b0;
         end
         if (le && (int'(la) / 4 < DEPTH)) m_mem[int'(la) / 4] = ld;
      end
      @(posedge clk);
      #1;
      m_valid = n_valid; m_inst = n_inst; m_fault = n_fault; m_cnt = n_cnt;
      chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_valid});
      chk("fetch_cnt", {16'd0, fetch_cnt}, {16'd0, m_cnt});
      if (m_valid) begin
         chk("rsp_inst", bus.rsp_inst, m_inst);
         chk("rsp_fault", {31'd0, bus.rsp_fault}, {31'd0, m_fault});
      end
   endtask

   task automatic fetch(input logic [ADDR_W-1:0] a, input logic rr);
      step(1'b0, 1'b1, a, rr, 1'b0, 1'b0, '0, 32'd0);
   endtask

   task automatic idle(input logic rr);
      step(1'b0, 1'b0, '0, rr, 1'b0, 1'b0, '0, 32'd0);
   endtask

   task automatic load(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      // req_valid held high to show loads block fetches
      step(1'b0, 1'b1, 10'h0, 1'b1, 1'b0, 1'b1, a, d);
   endtask

   initial begin
      logic [31:0] prog [4];
      int unsigned sel;
      logic [ADDR_W-1:0] ra, la;
      prog[0] = 32'h00300093; prog[1] = 32'h00208133;
      prog[2] = 32'h40110033; prog[3] = 32'h00000013;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
      m_valid = 1'b0; m_inst = NOP; m_fault = 1'b0; m_cnt = 16'd0;

      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 10'h0, 32'hDEAD_BEEF);
      step(1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, '0, 32'd0);
      chk("rst_ready", {31'd0, rdy_seen}, 32'd0);
      chk("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_inst", bus.rsp_inst, NOP);
      chk("rst_fault", {31'd0, bus.rsp_fault}, 32'd0);
      chk("rst_cnt", {16'd0, fetch_cnt}, 32'd0);

      // Word 0 written during reset must be ignored
      fetch(10'h000, 1'b1);
      chk("rst_ld_ignored", bus.rsp_inst, NOP);
      idle(1'b1);

      for (int i = 0; i < 4; i++) begin
         load(10'(i * 4), prog[i]);
         chk("ld_blocks_ready", {31'd0, rdy_seen}, 32'd0);
      end

      fetch(10'h004, 1'b1);
      chk("f4_inst", bus.rsp_inst, 32'h00208133);
      chk("f4_fault", {31'd0, bus.rsp_fault}, 32'd0);
      idle(1'b1);
      chk("f4_cnt", {16'd0, fetch_cnt}, 32'd2);

      fetch(10'h000, 1'b1);
      chk("b2b0", bus.rsp_inst, 32'h00300093);
      fetch(10'h004, 1'b1);
      chk("b2b1", bus.rsp_inst, 32'h00208133);
      chk("b2b1_valid", {31'd0, bus.rsp_valid}, 32'd1);
      fetch(10'h008, 1'b1);
      chk("b2b2", bus.rsp_inst, 32'h40110033);
      chk("b2b2_valid", {31'd0, bus.rsp_valid}, 32'd1);
      idle(1'b1);
      chk("b2b_cnt", {16'd0, fetch_cnt}, 32'd5);

      fetch(10'h000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         fetch(10'h004, 1'b0);
         chk("hold_ready", {31'd0, rdy_seen}, 32'd0);
         chk("hold_inst", bus.rsp_inst, 32'h00300093);
      end
      idle(1'b1);
      chk("hold_cnt", {16'd0, fetch_cnt}, 32'd6);
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd0);

      fetch(10'h006, 1'b1);
      chk("mis_fault", {31'd0, bus.rsp_fault}, 32'd1);
      chk("mis_inst", bus.rsp_inst, NOP);
      fetch(10'h100, 1'b1);
      chk("oor_fault", {31'd0, bus.rsp_fault}, 32'd1);
      chk("oor_inst", bus.rsp_inst, NOP);
      idle(1'b1);
      chk("fault_cnt", {16'd0, fetch_cnt}, 32'd6);

      fetch(10'h008, 1'b0);
      step(1'b0, 1'b1, 10'h0, 1'b0, 1'b1, 1'b0, '0, 32'd0);
      chk("flush_ready", {31'd0, rdy_seen}, 32'd0);
      chk("flush_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("flush_cnt", {16'd0, fetch_cnt}, 32'd6);

      // Flush together with a non-fault consume: counted, valid cleared
      fetch(10'h008, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 32'd0);
      chk("flush_consume_cnt", {16'd0, fetch_cnt}, 32'd7);

      // Load then fetch the same word next cycle
      load(10'h014, 32'hCAFE_0001);
      fetch(10'h014, 1'b1);
      chk("raw_inst", bus.rsp_inst, 32'hCAFE_0001);
      // Out-of-range load must not wrap onto word 0
      load(10'h100, 32'hBAD0_BAD0);
      fetch(10'h000, 1'b1);
      chk("oor_ld_nowrap", bus.rsp_inst, 32'h00300093);
      // Never-loaded word reads as the power-up NOP
      fetch(10'h050, 1'b1);
      chk("powerup_inst", bus.rsp_inst, NOP);
      chk("powerup_fault", {31'd0, bus.rsp_fault}, 32'd0);
      fetch(10'h00C, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 32'd0);
      chk("mrst_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("mrst_inst", bus.rsp_inst, NOP);
      chk("mrst_cnt", {16'd0, fetch_cnt}, 32'd0);
      fetch(10'h008, 1'b1);
      chk("post_rst_inst", bus.rsp_inst, 32'h40110033);
      idle(1'b1);

      for (int n = 0; n < 3000; n++) begin
         sel = $urandom_range(0, 99);
         if (sel < 60)      ra = 10'($urandom_range(0, DEPTH - 1) * 4);
         else if (sel < 80) ra = 10'($urandom_range(0, DEPTH * 4 - 1));
         else               ra = 10'($urandom_range(DEPTH * 4, 1023));
         la = ($urandom_range(0, 9) < 8) ? 10'($urandom_range(0, DEPTH * 4 - 1))
                                        : 10'($urandom_range(DEPTH * 4, 1023));
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 9) < 7,
              ra,
              $urandom_range(0, 9) < 6,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) == 0,
              la,
              $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
